// File: rtl/temp_sensor_poller.sv
// Periodic I2C temperature-sensor poller: reads NUM_BYTES bytes (MSB first) per
// sample at a power-mode dependent interval, with retry and timeout handling.

package temp_sensor_poller_pkg;
  localparam logic [6:0] TEMP_SENSOR_ADDR = 7'h48;
  localparam logic [1:0] PWR_NORMAL = 2'd0;
  localparam logic [1:0] PWR_LOW    = 2'd1;
  localparam logic [1:0] PWR_SLEEP  = 2'd2;
endpackage

module temp_sensor_poller
  import temp_sensor_poller_pkg::*;
#(
  parameter int          NUM_BYTES   = 2,
  parameter logic [6:0]  SLAVE_ADDR  = TEMP_SENSOR_ADDR,
  parameter int          INT_NORMAL  = 100000,
  parameter int          INT_LOW     = 200000,
  parameter int          INT_SLEEP   = 500000,
  parameter int          MAX_RETRY   = 2,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [1:0]             power_mode,
  input  logic                   force_read,
  output logic [8*NUM_BYTES-1:0] sensor_data,
  output logic                   data_valid,
  output logic                   busy,
  output logic                   sensor_error,
  output logic [1:0]             err_code,
  output logic                   start_read,
  output logic [6:0]             slave_addr,
  output logic                   read_write_n,
  output logic [7:0]             write_data,
  input  logic [7:0]             i2c_read_data,
  input  logic                   transaction_done,
  input  logic                   ack_error,
  output logic [2:0]             state_dbg
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, ISSUE, READ, DONE} state_t;

  state_t          state, state_n;
  logic [31:0]     int_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [RW-1:0]   retry_cnt;
  logic [1:0]      byte_idx;
  logic [W-1:0]    shreg;

  logic            load_int;
  logic            store_byte;
  logic            fail;
  logic            give_up;
  logic [1:0]      fail_code;
  logic            last_byte;

  // I2C side: start_read is a one-cycle request per byte; the master answers
  // with exactly one transaction_done or ack_error strobe, ignored outside READ.
  assign slave_addr   = SLAVE_ADDR;
  assign read_write_n = 1'b1;
  assign write_data   = 8'h00;
  assign state_dbg    = state;
  assign last_byte    = (byte_idx == 2'(NUM_BYTES - 1));

  function automatic logic [31:0] interval_for(input logic [1:0] mode);
    case (mode)
      PWR_LOW:   return 32'(INT_LOW);
      PWR_SLEEP: return 32'(INT_SLEEP);
      default:   return 32'(INT_NORMAL);
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    load_int   = 1'b0;
    store_byte = 1'b0;
    fail       = 1'b0;
    give_up    = 1'b0;
    fail_code  = 2'b00;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n  = WAIT;
          load_int = 1'b1;
        end
        WAIT: begin
          if (int_cnt == 32'd0 || force_read) state_n = ISSUE;
        end
        ISSUE: state_n = READ;
        READ: begin
          // NACK wins over a simultaneous completion; the byte is dropped.
          if (ack_error) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else if (transaction_done) begin
            store_byte = 1'b1;
            state_n    = last_byte ? DONE : ISSUE;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            fail      = 1'b1;
            fail_code = 2'b10;
          end
          if (fail) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
              state_n = ISSUE;
            end else begin
              give_up  = 1'b1;
              load_int = 1'b1;
              state_n  = WAIT;
            end
          end
        end
        DONE: begin
          load_int = 1'b1;
          state_n  = WAIT;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      int_cnt      <= '0;
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
      sensor_data  <= '0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      sensor_error <= 1'b0;
      err_code     <= 2'b00;
      start_read   <= 1'b0;
    end else begin
      state        <= state_n;
      busy         <= (state_n == ISSUE) || (state_n == READ) || (state_n == DONE);
      start_read   <= (state == ISSUE) && enable;
      data_valid   <= 1'b0;
      sensor_error <= 1'b0;
      if (load_int) int_cnt <= interval_for(power_mode);
      if (!enable) begin
        tmo_cnt   <= '0;
        retry_cnt <= '0;
        byte_idx  <= '0;
        shreg     <= '0;
      end else begin
        case (state)
          WAIT: begin
            if (state_n == ISSUE) byte_idx <= '0;
            else                  int_cnt  <= int_cnt - 32'd1;
          end
          ISSUE: tmo_cnt <= '0;
          READ: begin
            if (store_byte) begin
              shreg[8*(NUM_BYTES-1-int'(byte_idx)) +: 8] <= i2c_read_data;
              if (!last_byte) byte_idx <= byte_idx + 2'd1;
            end else if (!fail) begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (fail) begin
              byte_idx <= '0;
              if (give_up) begin
                sensor_error <= 1'b1;
                err_code     <= fail_code;
                retry_cnt    <= '0;
              end else begin
                retry_cnt <= retry_cnt + RW'(1);
              end
            end
          end
          DONE: begin
            sensor_data <= shreg;
            data_valid  <= 1'b1;
            retry_cnt   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_temp_sensor_poller.sv
// Directed bench for temp_sensor_poller: sampling, retry, NACK/timeout abandonment,
// force_read, enable drop and reset during a read.

module tb_temp_sensor_poller;
  import temp_sensor_poller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  power_mode;
  logic        force_read;
  logic [15:0] sensor_data;
  logic        data_valid;
  logic        busy;
  logic        sensor_error;
  logic [1:0]  err_code;
  logic        start_read;
  logic [6:0]  slave_addr;
  logic        read_write_n;
  logic [7:0]  write_data;
  logic [7:0]  i2c_read_data;
  logic        transaction_done;
  logic        ack_error;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int sr_cnt = 0;
  int dv_cnt = 0;
  int se_cnt = 0;

  temp_sensor_poller #(
    .NUM_BYTES(2), .SLAVE_ADDR(7'h48), .INT_NORMAL(10), .INT_LOW(20),
    .INT_SLEEP(520), .MAX_RETRY(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .power_mode(power_mode),
    .force_read(force_read), .sensor_data(sensor_data), .data_valid(data_valid),
    .busy(busy), .sensor_error(sensor_error), .err_code(err_code),
    .start_read(start_read), .slave_addr(slave_addr), .read_write_n(read_write_n),
    .write_data(write_data), .i2c_read_data(i2c_read_data),
    .transaction_done(transaction_done), .ack_error(ack_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start_read)   sr_cnt <= sr_cnt + 1;
    if (data_valid)   dv_cnt <= dv_cnt + 1;
    if (sensor_error) se_cnt <= se_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start_read && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(start_read), 32'd1);
  endtask

  // Serve one byte request: strobe one cycle after the request pulse.
  task automatic send_byte(input logic [7:0] d, input logic nack, input logic done);
    wait_start("start_seen");
    tick();
    check("start_one_cycle", 32'(start_read), 32'd0);
    i2c_read_data    = d;
    transaction_done = done;
    ack_error        = nack;
    tick();
    transaction_done = 1'b0;
    ack_error        = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; enable = 1'b0; power_mode = PWR_NORMAL; force_read = 1'b0;
    i2c_read_data = 8'h00; transaction_done = 1'b0; ack_error = 1'b0;
    tick(); tick();
    check("rst_sensor_data", 32'(sensor_data), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sensor_error", 32'(sensor_error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_start_read", 32'(start_read), 32'd0);
    check("slave_addr", 32'(slave_addr), 32'h48);
    check("read_write_n", 32'(read_write_n), 32'd1);
    check("write_data", 32'(write_data), 32'd0);

    // Basic two-byte sample.
    rst = 1'b0;
    tick();
    enable = 1'b1;
    n = 0;
    while (!start_read && n < 100) begin
      tick();
      n++;
    end
    check("first_start_latency", 32'(n), 32'd13);
    send_byte(8'h1A, 1'b0, 1'b1);
    send_byte(8'h2B, 1'b0, 1'b1);
    check("busy_in_done", 32'(busy), 32'd1);
    tick();
    check("dv_latency", 32'(data_valid), 32'd1);
    check("sample1_data", 32'(sensor_data), 32'h1A2B);
    check("sample1_starts", 32'(sr_cnt), 32'd2);
    n = 0;
    while (!start_read && n < 50) begin
      tick();
      n++;
      if (n == 1) check("dv_one_cycle", 32'(data_valid), 32'd0);
    end
    check("reload_interval", 32'(n), 32'd12);

    // One NACK on the first byte, then a clean retry.
    base = sr_cnt;
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b0, 1'b1);
    send_byte(8'h55, 1'b0, 1'b1);
    tick();
    check("retry_dv", 32'(data_valid), 32'd1);
    check("retry_data", 32'(sensor_data), 32'h4455);
    check("retry_starts", 32'(sr_cnt - base), 32'd3);
    check("retry_no_error", 32'(se_cnt), 32'd0);

    // Three attempts with NACK and completion together: abandoned as NACK.
    send_byte(8'h99, 1'b1, 1'b1);
    send_byte(8'h99, 1'b1, 1'b1);
    send_byte(8'h99, 1'b1, 1'b1);
    check("nack_error_pulse", 32'(sensor_error), 32'd1);
    check("nack_err_code", 32'(err_code), 32'd1);
    check("nack_data_held", 32'(sensor_data), 32'h4455);
    tick();
    check("nack_error_one_cycle", 32'(sensor_error), 32'd0);
    check("nack_no_dv", 32'(dv_cnt), 32'd2);

    // No response at all: three timeouts of 16 cycles each.
    wait_start("tmo_start_seen");
    n = 0;
    while (!sensor_error && n < 200) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'd50);
    check("timeout_err_code", 32'(err_code), 32'd2);
    check("timeout_data_held", 32'(sensor_data), 32'h4455);
    check("timeout_error_count", 32'(se_cnt), 32'd1);

    // force_read ignored in IDLE, honoured in WAIT with a long interval.
    enable = 1'b0;
    tick();
    force_read = 1'b1;
    tick();
    force_read = 1'b0;
    tick(); tick();
    check("force_idle_ignored", 32'(start_read), 32'd0);
    check("idle_state", 32'(state_dbg), 32'd0);
    power_mode = PWR_SLEEP;
    enable = 1'b1;
    repeat (20) tick();
    force_read = 1'b1;
    tick();
    force_read = 1'b0;
    check("force_not_yet", 32'(start_read), 32'd0);
    tick();
    check("force_latency", 32'(start_read), 32'd1);
    send_byte(8'h77, 1'b0, 1'b1);
    wait_start("second_byte_start");
    enable = 1'b0;
    tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_start_read", 32'(start_read), 32'd0);
    check("drop_state_idle", 32'(state_dbg), 32'd0);
    i2c_read_data = 8'hEE;
    transaction_done = 1'b1;
    tick();
    transaction_done = 1'b0;
    tick(); tick();
    check("drop_no_dv", 32'(dv_cnt), 32'd2);
    check("drop_data_held", 32'(sensor_data), 32'h4455);
    check("err_code_held", 32'(err_code), 32'd2);

    // Reset in the middle of a read.
    power_mode = PWR_NORMAL;
    enable = 1'b1;
    wait_start("pre_reset_start");
    check("busy_in_read", 32'(busy), 32'd1);
    rst = 1'b1;
    transaction_done = 1'b1;
    i2c_read_data = 8'h5A;
    tick();
    rst = 1'b0;
    transaction_done = 1'b0;
    check("mid_rst_data", 32'(sensor_data), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(start_read), 32'd0);
    check("mid_rst_dv", 32'(data_valid), 32'd0);
    check("mid_rst_err", 32'(sensor_error), 32'd0);
    check("mid_rst_code", 32'(err_code), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
